instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage for the 16-bit RISC core. It sits directly upstream of the datapath/control pair. It owns the program counter and issues word reads to a fixed-latency instruction memory. Returned instructions are buffered in a small prefetch FIFO and delivered to the decoder over a valid/ready handshake; a redirect input flushes the FIFO and restarts fetch at a new address for branches and jumps.

## Interface
- ADDR_W, 8, instruction-memory word-address width (PC width)
- DEPTH, 4, prefetch FIFO entries; power of two, ≥ 2
- RESET_PC, 0, PC value loaded on reset
- clk  input  1  rising-edge clock, sole clock
- rst_n  input  1  reset, asynchronous assert, active-low
- imem_req  output  1  read request this cycle
- imem_addr  output  ADDR_W  word address of the request
- imem_rdata  input  16  read data, valid exactly 1 cycle after the request
- redirect  input  1  flush and restart fetch
- redirect_pc  input  ADDR_W  restart address, sampled when redirect=1
- instr_valid  output  1  FIFO head holds a valid instruction
- instr_ready  input  1  consumer accepts head this cycle
- instr  output  16  head instruction
- instr_pc  output  ADDR_W  address the head was fetched from
- opcode  output  4  instr[15:12], for control-unit decode

## Operation
- State: pc (next fetch address), FIFO (DEPTH entries of {instr, pc}), count, inflight flag (request issued last cycle), drop flag.
- Issue rule: imem_req=1 when redirect=0 and count + inflight < DEPTH (credit check). On issue: imem_addr=pc, then pc ← pc+1 mod 2^ADDR_W (0xFF → 0x00 wraps silently).
- Response: cycle after an issue, imem_rdata is pushed with its address, unless drop=1, in which case it is discarded.
- Pop: instr_valid && instr_ready removes the head. Push and pop in the same cycle leave count unchanged.
- The credit rule makes overflow impossible. A push while full is a design error (assert in bench).
- Redirect (priority over everything except reset):
  - FIFO count ← 0.
  - pc ← redirect_pc.
  - imem_req forced 0 that cycle.
  - drop ← inflight, so the response to a request issued in the redirect cycle's predecessor is discarded.
  - A handshake occurring in the redirect cycle is still a completed transfer from the consumer's view.
- instr, instr_pc and opcode are driven from the FIFO head and are don't-care when instr_valid=0.
- No combinational path from instr_ready or redirect to instr_valid/instr. imem_req depends combinationally on redirect only.

## Timing
- Reset (rst_n=0, async): pc=RESET_PC, count=0, inflight=0, drop=0.
  - Outputs during reset: imem_req=0, imem_addr=RESET_PC, instr_valid=0.
  - Reset mid-operation abandons any in-flight read. Its response is ignored because inflight is cleared.
- First request in the first clk edge cycle after rst_n deasserts (cycle C0). Data returns in C1, is written at the end of C1, and instr_valid=1 in C2.
  - Fetch-to-valid latency: 2 cycles.
- Sustained throughput: 1 instruction/cycle with instr_ready held high.
- Backpressure with instr_ready=0: requests stop once count + inflight = DEPTH, so at most DEPTH instructions are buffered.
  - The first request after a pop is issued in the cycle following that pop.
- Redirect asserted in cycle R:
  - No request in R.
  - First request to redirect_pc in R+1.
  - instr_valid=0 from R+1 through R+2.
  - The new-path head is valid in R+3.
- Back-to-back redirects: the latest wins. Each one restarts the R+1 request timing.
- Redirect while empty with no request in flight: drop stays 0, and the same timing applies.

## Test plan
- Reset release, imem returns mem[a]=0x1000+a, instr_ready=1 → instr_valid rises 2 cycles after rst_n; instr/instr_pc sequence 0x1000/0, 0x1001/1, … one per cycle; opcode=0x1.
- instr_ready=0 for 10 cycles after start → exactly DEPTH=4 requests issued, imem_req stays 0; on release, pops continue with no gap or duplication (pc 0..7 in order).
- redirect with redirect_pc=0x40 while 3 entries are buffered and 1 request is in flight → no old-path instruction appears after R. First output is instr_pc=0x40, valid at R+3.
- RESET_PC=0xFE, free-running → instr_pc sequence 0xFE, 0xFF, 0x00, 0x01.
- Redirect in consecutive cycles to 0x10 then 0x20 → only the 0x20 path is delivered. No fetch to 0x10 data reaches the output.
- rst_n pulsed low asynchronously while the FIFO is full → outputs take reset values immediately. Fetch restarts at RESET_PC with the normal 2-cycle latency.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues 1-cycle imem reads into a DEPTH-entry prefetch FIFO; fetch-to-valid 2 cycles.
// Credit-based: requests stall while buffered + in-flight == DEPTH; redirect flushes and restarts at redirect_pc.
module instr_fetch_unit #(
  parameter int                 ADDR_W   = 8,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [3:0]        opcode
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              inflight_q, inflight_d;
  logic              drop_q, drop_d;
  logic              run_q, run_d;
  logic [15:0]       fifo_instr_q [DEPTH];
  logic [15:0]       fifo_instr_d [DEPTH];
  logic [ADDR_W-1:0] fifo_pc_q [DEPTH];
  logic [ADDR_W-1:0] fifo_pc_d [DEPTH];

  logic [CNT_W:0]    credit_used;
  logic              push;
  logic              pop;

  // run_q keeps imem_req low while reset is held and releases it on the first edge afterwards.
  assign credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign imem_req    = run_q && !redirect && (credit_used < (CNT_W+1)'(DEPTH));
  assign imem_addr   = pc_q;

  assign instr_valid = (count_q != '0);
  assign instr       = fifo_instr_q[rd_ptr_q];
  assign instr_pc    = fifo_pc_q[rd_ptr_q];
  assign opcode      = instr[15:12];

  assign push = inflight_q && !drop_q;
  assign pop  = instr_valid && instr_ready;

  always_comb begin
    pc_d         = pc_q;
    req_pc_d     = pc_q;
    inflight_d   = imem_req;
    drop_d       = 1'b0;
    run_d        = 1'b1;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;

    if (imem_req) begin
      pc_d = pc_q + ADDR_W'(1);
    end

    if (redirect) begin
      // Flush wins over any push/pop this cycle; a pop here still counts as delivered.
      pc_d     = redirect_pc;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      drop_d   = inflight_q;
    end else begin
      if (push) begin
        fifo_instr_d[wr_ptr_q] = imem_rdata;
        fifo_pc_d[wr_ptr_q]    = req_pc_q;
        wr_ptr_d               = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      run_q      <= run_d;
    end
  end

  // Payload storage needs no reset: entries are only read when count_q says they were written.
  always_ff @(posedge clk) begin
    fifo_instr_q <= fifo_instr_d;
    fifo_pc_q    <= fifo_pc_d;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + random bench for instr_fetch_unit against a queue-based model of fetched, not-yet-delivered instructions.
module tb_instr_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req, instr_valid, instr_ready, redirect;
  logic [7:0]  imem_addr, redirect_pc, instr_pc;
  logic [15:0] imem_rdata, instr;
  logic [3:0]  opcode;

  logic        w_imem_req, w_instr_valid;
  logic        w_instr_ready = 1'b1;
  logic        w_redirect    = 1'b0;
  logic [7:0]  w_redirect_pc = 8'h00;
  logic [7:0]  w_imem_addr, w_instr_pc;
  logic [15:0] w_imem_rdata, w_instr;
  logic [3:0]  w_opcode;

  instr_fetch_unit #(.ADDR_W(8), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .opcode(opcode)
  );

  instr_fetch_unit #(.ADDR_W(8), .DEPTH(DEPTH), .RESET_PC(8'hFE)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_rdata(w_imem_rdata), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .instr_valid(w_instr_valid), .instr_ready(w_instr_ready), .instr(w_instr),
    .instr_pc(w_instr_pc), .opcode(w_opcode)
  );

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] dat;
    int          avail;
  } ent_t;

  ent_t        q[$];
  logic [15:0] mem [256];
  int          now = 0;
  int          total = 0;
  int          passed = 0;
  int          nreq = 0;
  int          w_pops = 0;
  logic [7:0]  fetch_pc;
  logic [7:0]  w_exp;
  bit          started;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Called at a negedge with this cycle's inputs already applied; returns at the next negedge.
  task automatic cycle();
    bit         exp_req, exp_valid;
    bit         r_req, r_wreq;
    logic [7:0] r_addr, r_waddr;
    ent_t       e;
    #1;
    exp_req   = started && !redirect && (q.size() < DEPTH);
    exp_valid = (q.size() > 0) && (q[0].avail <= now);
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, fetch_pc);
    check("instr_valid", instr_valid, exp_valid);
    if (exp_valid) begin
      check("instr_pc", instr_pc, q[0].pc);
      check("instr", instr, q[0].dat);
      check("opcode", opcode, q[0].dat[15:12]);
    end
    if (w_instr_valid) begin
      check("wrap_pc", w_instr_pc, w_exp);
      w_exp++;
      w_pops++;
    end
    if (imem_req) nreq++;
    if (exp_valid && instr_ready) void'(q.pop_front());
    if (redirect) begin
      q.delete();
      fetch_pc = redirect_pc;
    end else if (exp_req) begin
      e.pc = fetch_pc; e.dat = mem[fetch_pc]; e.avail = now + 2;
      q.push_back(e);
      fetch_pc++;
    end
    r_req = imem_req; r_addr = imem_addr; r_wreq = w_imem_req; r_waddr = w_imem_addr;
    @(posedge clk);
    now++;
    if (rst_n) started = 1'b1;
    #1;
    imem_rdata   = r_req  ? mem[r_addr]  : 16'($urandom);
    w_imem_rdata = r_wreq ? mem[r_waddr] : 16'($urandom);
    @(negedge clk);
  endtask

  task automatic hold_reset(input int n);
    rst_n = 1'b0;
    q.delete();
    started  = 1'b0;
    fetch_pc = 8'h00;
    w_exp    = 8'hFE;
    #1;
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_imem_addr", imem_addr, 8'h00);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_w_imem_addr", w_imem_addr, 8'hFE);
    check("rst_w_valid", w_instr_valid, 1'b0);
    repeat (n) cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; instr_ready = 1'b0;
    imem_rdata = 16'h0; w_imem_rdata = 16'h0;
    for (int a = 0; a < 256; a++) mem[a] = 16'h1000 + 16'(a);
    @(negedge clk);

    // Reset release, free-running consumer: valid two cycles after the first request.
    hold_reset(3);
    instr_ready = 1'b1;
    cycle(); cycle();
    check("first_valid_early", instr_valid, 1'b0);
    cycle();
    check("first_valid", instr_valid, 1'b1);
    check("first_pc", instr_pc, 8'h00);
    check("first_instr", instr, 16'h1000);
    repeat (10) cycle();

    // Backpressure from start: exactly DEPTH requests, then in-order drain.
    hold_reset(2);
    instr_ready = 1'b0;
    nreq = 0;
    repeat (10) cycle();
    check("bp_requests", nreq, DEPTH);
    instr_ready = 1'b1;
    repeat (10) cycle();

    // Redirect with 3 buffered and 1 in flight.
    instr_ready = 1'b0;
    repeat (6) cycle();
    instr_ready = 1'b1; cycle();
    instr_ready = 1'b0; cycle();
    redirect = 1'b1; redirect_pc = 8'h40; cycle();
    redirect = 1'b0; instr_ready = 1'b1;
    check("redir_r1_valid", instr_valid, 1'b0);
    cycle();
    check("redir_r2_valid", instr_valid, 1'b0);
    cycle();
    check("redir_r3_valid", instr_valid, 1'b1);
    check("redir_r3_pc", instr_pc, 8'h40);
    repeat (6) cycle();

    // Back-to-back redirects: latest target wins.
    redirect = 1'b1; redirect_pc = 8'h10; cycle();
    redirect_pc = 8'h20; cycle();
    redirect = 1'b0;
    cycle(); cycle();
    check("b2b_valid", instr_valid, 1'b1);
    check("b2b_pc", instr_pc, 8'h20);
    repeat (6) cycle();

    // Random traffic with random memory contents.
    for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
    for (int i = 0; i < 400; i++) begin
      instr_ready = ($urandom_range(9) < 7);
      redirect    = ($urandom_range(19) == 0);
      redirect_pc = 8'($urandom);
      cycle();
    end
    redirect = 1'b0;

    // Asynchronous reset mid-cycle while the FIFO is full.
    instr_ready = 1'b0;
    repeat (8) cycle();
    check("full_before_rst", instr_valid, 1'b1);
    #2;
    hold_reset(2);
    instr_ready = 1'b1;
    cycle(); cycle();
    check("post_rst_early", instr_valid, 1'b0);
    cycle();
    check("post_rst_valid", instr_valid, 1'b1);
    check("post_rst_pc", instr_pc, 8'h00);
    repeat (5) cycle();

    check("wrap_delivered", (w_pops >= 4), 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
